// File: rtl/canvas_downsampler.sv
// Box-averages each 16x16 block of a raster pixel stream into one byte of a GRIDxGRID image RAM.
// The RAM write lands two edges after the block's last pixel; there is no backpressure and a pixel is accepted every cycle.
module canvas_downsampler #(
  parameter int S_X    = 16,
  parameter int S_Y    = 16,
  parameter int GRID   = 28,
  parameter bit INVERT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [11:0] pix_x,
  input  logic [11:0] pix_y,
  input  logic [7:0]  pix_data,
  output logic        ram_we,
  output logic [9:0]  ram_waddr,
  output logic [7:0]  ram_wdata,
  output logic        frame_done
);

  localparam int          CW        = $clog2(GRID);
  localparam logic [11:0] WIN       = 12'(GRID * 16);
  localparam logic [11:0] SX        = 12'(S_X);
  localparam logic [11:0] SY        = 12'(S_Y);
  localparam logic [9:0]  LAST_ADDR = 10'(GRID * GRID - 1);

  logic [11:0]   dx;
  logic [11:0]   dy;
  logic          in_win;

  logic          s1_vld_q,  s1_vld_d;
  logic [CW-1:0] s1_col_q,  s1_col_d;
  logic [CW-1:0] s1_row_q,  s1_row_d;
  logic [7:0]    s1_data_q, s1_data_d;
  logic          s1_last_q, s1_last_d;

  logic [15:0]   acc_q [GRID];
  logic [15:0]   acc_d [GRID];
  logic [15:0]   sum;

  logic          ram_we_q,     ram_we_d;
  logic [9:0]    ram_waddr_q,  ram_waddr_d;
  logic [7:0]    ram_wdata_q,  ram_wdata_d;
  logic          frame_done_q, frame_done_d;

  // Stage 1: window test and coordinate split
  always_comb begin
    dx = pix_x - SX;
    dy = pix_y - SY;
    // Coordinates left of / above the window wrap to huge offsets, so one compare per axis covers both edges.
    in_win    = (dx < WIN) && (dy < WIN);
    s1_vld_d  = pix_valid && in_win && !frame_start;
    s1_col_d  = dx[4 +: CW];
    s1_row_d  = dy[4 +: CW];
    s1_data_d = pix_data;
    s1_last_d = (dx[3:0] == 4'hf) && (dy[3:0] == 4'hf);
  end

  // Stage 2: accumulate per column, emit the cell on the block's last pixel
  always_comb begin
    acc_d        = acc_q;
    ram_we_d     = 1'b0;
    ram_waddr_d  = ram_waddr_q;
    ram_wdata_d  = ram_wdata_q;
    frame_done_d = ram_we_q && (ram_waddr_q == LAST_ADDR);
    sum          = acc_q[s1_col_q] + {8'h00, s1_data_q};
    if (frame_start) begin
      for (int i = 0; i < GRID; i++) begin
        acc_d[i] = '0;
      end
    end else if (s1_vld_q) begin
      if (s1_last_q) begin
        ram_we_d         = 1'b1;
        ram_waddr_d      = 10'(s1_row_q) * 10'(GRID) + 10'(s1_col_q);
        ram_wdata_d      = INVERT ? ~sum[15:8] : sum[15:8];
        acc_d[s1_col_q]  = '0;
      end else begin
        acc_d[s1_col_q]  = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q     <= 1'b0;
      s1_col_q     <= '0;
      s1_row_q     <= '0;
      s1_data_q    <= '0;
      s1_last_q    <= 1'b0;
      for (int i = 0; i < GRID; i++) begin
        acc_q[i] <= '0;
      end
      ram_we_q     <= 1'b0;
      ram_waddr_q  <= '0;
      ram_wdata_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_col_q     <= s1_col_d;
      s1_row_q     <= s1_row_d;
      s1_data_q    <= s1_data_d;
      s1_last_q    <= s1_last_d;
      acc_q        <= acc_d;
      ram_we_q     <= ram_we_d;
      ram_waddr_q  <= ram_waddr_d;
      ram_wdata_q  <= ram_wdata_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_waddr  = ram_waddr_q;
  assign ram_wdata  = ram_wdata_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_canvas_downsampler.sv
// Randomised raster frames against a block-sum model; a 6x6 grid keeps each frame near 10k cycles.
module tb_canvas_downsampler;

  localparam int SX = 16;
  localparam int SY = 16;
  localparam int G  = 6;
  localparam int W  = G * 16;
  localparam int NC = G * G;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [11:0] pix_x = '0;
  logic [11:0] pix_y = '0;
  logic [7:0]  pix_data = '0;
  logic        we0, we1, fd0, fd1;
  logic [9:0]  a0, a1;
  logic [7:0]  d0, d1;

  canvas_downsampler #(.S_X(SX), .S_Y(SY), .GRID(G), .INVERT(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .ram_we(we0), .ram_waddr(a0), .ram_wdata(d0), .frame_done(fd0));

  canvas_downsampler #(.S_X(SX), .S_Y(SY), .GRID(G), .INVERT(1'b1)) u_dut_inv (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .ram_we(we1), .ram_waddr(a1), .ram_wdata(d1), .frame_done(fd1));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int mem0[NC];
  int mem1[NC];
  int wr_tot = 0;
  int fd_tot = 0;
  int wr_base, fd_base;
  bit prev_last = 1'b0;
  int hold_a = 0;
  int hold_d = 0;
  int mode, uval, seed;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int pixval(input int x, input int y);
    bit inw = (x >= SX) && (x < SX + W) && (y >= SY) && (y < SY + W);
    case (mode)
      0: return inw ? uval : 255;
      1: begin
        if (!inw) return 255;
        if (x >= 96 && x < 112 && y >= 64 && y < 80) return 255;
        if (x < SX + 16 && y < SY + 8) return 255;
        return 0;
      end
      default: return ((x * 131 + y * 197 + seed) ^ (x * y)) & 255;
    endcase
  endfunction

  // Every RAM write must be the next expected cell; idle cycles must hold the last write.
  always @(negedge clk) begin
    int e;
    if (!rst_n) begin
      prev_last = 1'b0;
      hold_a    = 0;
      hold_d    = 0;
    end else begin
      chk("frame_done", int'(fd0), int'(prev_last));
      chk("frame_done_inv", int'(fd1), int'(prev_last));
      chk("we_inv_vs_plain", int'(we1), int'(we0));
      if (we0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", int'(a0), -1);
        end else begin
          e = exp_q.pop_front();
          chk("waddr", int'(a0), e >> 8);
          chk("wdata", int'(d0), e & 255);
          chk("waddr_inv", int'(a1), e >> 8);
          chk("wdata_inv", int'(d1), 255 - (e & 255));
          if (a0 < NC) mem0[a0] = int'(d0);
          if (a1 < NC) mem1[a1] = int'(d1);
          wr_tot++;
        end
        hold_a = int'(a0);
        hold_d = int'(d0);
      end else begin
        chk("hold_addr", int'(a0), hold_a);
        chk("hold_data", int'(d0), hold_d);
      end
      prev_last = we0 && (a0 == 10'(NC - 1));
      if (fd0) fd_tot++;
    end
  end

  task automatic stream(input int y_last, input bit use_fs);
    int s;
    for (int r = 0; r < G; r++) begin
      for (int c = 0; c < G; c++) begin
        if (SY + 16 * r + 15 <= y_last) begin
          s = 0;
          for (int y = SY + 16 * r; y < SY + 16 * r + 16; y++)
            for (int x = SX + 16 * c; x < SX + 16 * c + 16; x++)
              s += pixval(x, y);
          exp_q.push_back(((r * G + c) << 8) | (s >> 8));
        end
      end
    end
    wr_base = wr_tot;
    fd_base = fd_tot;
    if (use_fs) begin
      // This pixel sits on a block-last position and must be dropped by frame_start.
      @(negedge clk);
      frame_start = 1'b1; pix_valid = 1'b1;
      pix_x = 12'(SX + 15); pix_y = 12'(SY + 15); pix_data = 8'hff;
    end
    for (int y = 14; y <= y_last; y++) begin
      for (int x = 12; x <= SX + W + 1; x++) begin
        while ($urandom_range(15) == 0) begin
          @(negedge clk);
          frame_start = 1'b0; pix_valid = 1'b0;
          pix_x = 12'($urandom_range(SX + W)); pix_y = 12'($urandom_range(SY + W));
          pix_data = 8'($urandom);
        end
        @(negedge clk);
        frame_start = 1'b0; pix_valid = 1'b1;
        pix_x = 12'(x); pix_y = 12'(y); pix_data = 8'(pixval(x, y));
      end
    end
    @(negedge clk);
    frame_start = 1'b0; pix_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("expected_writes_drained", exp_q.size(), 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("reset_we", int'(we0), 0);
    chk("reset_addr", int'(a0), 0);
    chk("reset_data", int'(d0), 0);
    chk("reset_done", int'(fd0), 0);
    chk("reset_data_inv", int'(d1), 0);
    @(posedge clk); #2 rst_n = 1'b1;

    mode = 0; uval = 200;
    stream(SY + W + 1, 1'b1);
    chk("uniform_write_count", wr_tot - wr_base, NC);
    chk("uniform_done_count", fd_tot - fd_base, 1);
    chk("uniform_cell5", mem0[5], 200);
    chk("uniform_cell_last_inv", mem1[NC - 1], 55);

    mode = 1;
    stream(SY + W + 1, 1'b1);
    chk("half_block_cell0", mem0[0], 127);
    chk("half_block_cell0_inv", mem1[0], 128);
    chk("single_block_cell23", mem0[23], 255);
    chk("zero_cell1", mem0[1], 0);
    chk("pattern_done_count", fd_tot - fd_base, 1);

    mode = 2; seed = int'($urandom_range(1000));
    stream(SY + 48 + 5, 1'b1);
    chk("abort_write_count", wr_tot - wr_base, 3 * G);
    chk("abort_done_count", fd_tot - fd_base, 0);

    mode = 0; uval = 50;
    stream(SY + W + 1, 1'b1);
    chk("after_abort_count", wr_tot - wr_base, NC);
    chk("after_abort_cell_last", mem0[NC - 1], 50);
    chk("after_abort_cell18", mem0[18], 50);

    mode = 2; seed = int'($urandom_range(1000));
    stream(SY + 16 + 7, 1'b1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midreset_we", int'(we0), 0);
    chk("midreset_addr", int'(a0), 0);
    chk("midreset_data", int'(d0), 0);
    @(posedge clk); #2 rst_n = 1'b1;

    mode = 0; uval = 77;
    stream(SY + W + 1, 1'b0);
    chk("after_reset_count", wr_tot - wr_base, NC);
    chk("after_reset_cell0", mem0[0], 77);
    chk("after_reset_cell_last", mem0[NC - 1], 77);

    mode = 2; seed = int'($urandom_range(1000));
    stream(SY + W + 1, 1'b1);
    chk("random_write_count", wr_tot - wr_base, NC);
    chk("random_done_count", fd_tot - fd_base, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
